// File: rtl/axis_write_sched.sv
// Command-queue sequencer for one axis_write: buffers (addr, len) commands, issues the
// three-word config sequence per command and pulses done once the stream words are accepted.
module axis_write_sched #(
   parameter int unsigned CONFIG_ID     = 1,
   parameter int unsigned CONFIG_ADDR   = 23,
   parameter int unsigned CONFIG_DATA   = 24,
   parameter int unsigned CONFIG_AWIDTH = 5,
   parameter int unsigned CONFIG_DWIDTH = 32,
   parameter int unsigned CMD_AWIDTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CONFIG_DWIDTH-1:0] cmd_addr_i,
   input  logic [CONFIG_DWIDTH-1:0] cmd_len_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   output logic [CONFIG_AWIDTH-1:0] cfg_addr_o,
   output logic [CONFIG_DWIDTH-1:0] cfg_data_o,
   output logic                     cfg_valid_o,
   input  logic                     str_valid_i,
   input  logic                     str_ready_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [CMD_AWIDTH:0]      pending_o
);

   localparam int unsigned Depth = 2 ** CMD_AWIDTH;
   localparam int unsigned CntW  = CMD_AWIDTH + 1;

   typedef enum logic [5:0] {
      StIdle = 6'b000001,
      StId   = 6'b000010,
      StAddr = 6'b000100,
      StLen  = 6'b001000,
      StRun  = 6'b010000,
      StDone = 6'b100000
   } state_e;

   state_e state_q, state_d;

   logic [CONFIG_DWIDTH-1:0] fifo_addr_q [Depth];
   logic [CONFIG_DWIDTH-1:0] fifo_len_q  [Depth];
   logic [CMD_AWIDTH-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CMD_AWIDTH:0]      count_q, count_d;
   logic                     ready_q;

   logic [CONFIG_DWIDTH-1:0] cmd_addr_q, cmd_len_q;
   logic [CONFIG_DWIDTH-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;

   logic                     cfg_valid_q, cfg_valid_d;
   logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
   logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic push, pop, hs;

   assign push         = cmd_valid_i & ready_q;
   assign pop          = (state_q == StIdle) && (count_q != '0);
   assign hs           = str_valid_i & str_ready_i;
   assign word_cnt_inc = word_cnt_q + CONFIG_DWIDTH'(hs);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + CMD_AWIDTH'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + CMD_AWIDTH'(1);
         count_q <= count_d;
         // Occupancy never exceeds Depth, so its MSB alone flags a full FIFO.
         ready_q <= ~count_d[CMD_AWIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= cmd_addr_i;
         fifo_len_q[wr_ptr_q]  <= cmd_len_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         word_cnt_q  <= '0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         if (pop) begin
            cmd_addr_q <= fifo_addr_q[rd_ptr_q];
            cmd_len_q  <= fifo_len_q[rd_ptr_q];
         end
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               word_cnt_d = '0;
               state_d    = (fifo_len_q[rd_ptr_q] == '0) ? StDone : StId;
            end
         end
         StId: begin
            word_cnt_d = word_cnt_inc;
            state_d    = StAddr;
         end
         StAddr: begin
            word_cnt_d = word_cnt_inc;
            state_d    = StLen;
         end
         StLen: begin
            word_cnt_d = word_cnt_inc;
            state_d    = StRun;
         end
         StRun: begin
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == cmd_len_q) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      cfg_valid_d = 1'b0;
      cfg_addr_d  = '0;
      cfg_data_d  = '0;
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      unique case (state_d)
         StId: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
            cfg_data_d  = CONFIG_DWIDTH'(CONFIG_ID);
         end
         StAddr: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
            cfg_data_d  = cmd_addr_q;
         end
         StLen: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
            cfg_data_d  = cmd_len_q;
         end
         default: ;
      endcase
   end

   assign cmd_ready_o = ready_q;
   assign cfg_valid_o = cfg_valid_q;
   assign cfg_addr_o  = cfg_addr_q;
   assign cfg_data_o  = cfg_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pending_o   = count_q;

endmodule

// File: tb/tb_axis_write_sched.sv
// Randomized bench for axis_write_sched: a cycle-timeline model of the command queue predicts
// every output each cycle; scenario tasks drive traffic and compare inline.
module tb_axis_write_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cmd_addr, cmd_len;
   logic        cmd_valid, cmd_ready;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_valid, str_valid, str_ready, busy, done;
   logic [2:0]  pending;

   axis_write_sched dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_addr_i (cmd_addr),
      .cmd_len_i  (cmd_len),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cfg_addr_o (cfg_addr),
      .cfg_data_o (cfg_data),
      .cfg_valid_o(cfg_valid),
      .str_valid_i(str_valid),
      .str_ready_i(str_ready),
      .busy_o     (busy),
      .done_o     (done),
      .pending_o  (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [31:0] a; logic [31:0] l;} cmd_t;

   cmd_t        tx_q[$];        // commands the bench still has to offer
   cmd_t        mq[$];          // model FIFO contents
   cmd_t        cur;            // model: command in flight
   bit          act;
   int          pop_c, done_c = -1, hs_n, cyc_n;
   bit          ref_ok, chk;
   bit          drv_rst, push_en, hs_mask;
   int unsigned hs_pct;
   logic [43:0] obs_v, exp_v;
   int          n_cmp, n_fail, done_seen, cfg_seen, done_obs_cyc, id_obs_cyc;
   logic [31:0] addr_log[$], exp_addrs[$];
   logic [36:0] cfg_log[$];
   logic [4:0]  prev_cfg_addr;

   // A handshake may only be offered where it cannot overshoot the command length.
   function automatic bit hs_allowed();
      int off;
      off = cyc_n - pop_c;
      if (hs_mask) return act && off >= 2 && off <= 4 && done_c < 0;
      return !(act && off >= 1 && done_c >= 0 && cyc_n < done_c);
   endfunction

   task automatic cyc();
      int   off;
      bit   ev, hs, do_pop, do_push, ending;
      logic [4:0]  ea;
      logic [31:0] ed;
      rst       = drv_rst;
      cmd_valid = push_en && (tx_q.size() != 0);
      if (tx_q.size() != 0) begin
         cmd_addr = tx_q[0].a;
         cmd_len  = tx_q[0].l;
      end else begin
         cmd_addr = $urandom;
         cmd_len  = $urandom;
      end
      str_valid = ($urandom_range(99) < hs_pct);
      str_ready = hs_allowed() && ($urandom_range(99) < hs_pct);
      @(negedge clk);
      off   = act ? cyc_n - pop_c : 0;
      ev    = act && cur.l != 0 && off >= 1 && off <= 3;
      ea    = !ev ? 5'd0 : (off == 1 ? 5'd23 : 5'd24);
      ed    = !ev ? 32'd0 : (off == 1 ? 32'd1 : (off == 2 ? cur.a : cur.l));
      exp_v = {ev, ea, ed, act && off >= 1, act && done_c == cyc_n, 3'(mq.size()),
               mq.size() < 4};
      obs_v = {cfg_valid, cfg_addr, cfg_data, busy, done, pending, cmd_ready};
      chk   = ref_ok;
      if (cfg_valid === 1'b1) begin
         cfg_log.push_back({cfg_addr, cfg_data});
         cfg_seen++;
         if (cfg_addr == 5'd23) id_obs_cyc = cyc_n;
         if (cfg_addr == 5'd24 && prev_cfg_addr == 5'd23) addr_log.push_back(cfg_data);
      end
      prev_cfg_addr = (cfg_valid === 1'b1) ? cfg_addr : 5'd0;
      if (done === 1'b1) begin
         done_seen++;
         done_obs_cyc = cyc_n;
      end
      if (drv_rst) begin
         mq.delete();
         act    = 0;
         done_c = -1;
         ref_ok = 1;
      end else begin
         hs = str_valid && str_ready;
         if (act && off >= 1 && done_c < 0 && hs) begin
            hs_n++;
            if (hs_n == int'(cur.l)) done_c = (cyc_n + 1 > pop_c + 5) ? cyc_n + 1 : pop_c + 5;
         end
         ending  = act && done_c == cyc_n;
         do_pop  = !act && mq.size() != 0;
         do_push = cmd_valid && mq.size() < 4;
         if (ending) act = 0;
         if (do_pop) begin
            cur    = mq.pop_front();
            act    = 1;
            pop_c  = cyc_n;
            hs_n   = 0;
            done_c = (cur.l == 0) ? cyc_n + 1 : -1;
         end
         if (do_push) mq.push_back(tx_q.pop_front());
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] l);
      tx_q.push_back('{a, l});
      if (l != 0) exp_addrs.push_back(a);
   endtask

   task automatic test_reset();
      drv_rst = 1;
      push_en = 0;
      hs_pct  = 0;
      repeat (3) begin
         cyc();
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL reset cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (obs_v !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values got=%h want=%h", obs_v, {1'b0, 37'd0, 5'b00001});
      end
      drv_rst = 0;
   endtask

   task automatic test_single();
      int n = 0, d0 = done_seen;
      logic [36:0] want[3];
      want = '{{5'd23, 32'd1}, {5'd24, 32'h1000}, {5'd24, 32'd8}};
      cfg_log.delete();
      offer(32'h1000, 32'd8);
      push_en = 1;
      hs_pct  = 60;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 500) begin
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL single cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (n >= 500) begin
         n_fail++;
         $display("FAIL single_timeout cycles=%0d limit=500", n);
      end
      repeat (2) cyc();
      n_cmp++;
      if (busy !== 1'b0 || done_seen - d0 != 1) begin
         n_fail++;
         $display("FAIL single_done busy=%b dones=%0d want busy=0 dones=1", busy, done_seen - d0);
      end
      n_cmp++;
      if (cfg_log.size() != 3 || cfg_log[0] !== want[0] || cfg_log[1] !== want[1] ||
          cfg_log[2] !== want[2]) begin
         n_fail++;
         $display("FAIL single_cfg writes=%0d want 3 (23,1)(24,1000)(24,8)", cfg_log.size());
      end
   endtask

   task automatic test_fill();
      int n = 0, d0 = done_seen;
      bit ok;
      addr_log.delete();
      exp_addrs.delete();
      offer($urandom, 32'd1);
      push_en = 1;
      hs_pct  = 0;
      while (!(act && cyc_n - pop_c >= 4) && n < 50) begin
         cyc();
         n++;
      end
      for (int i = 0; i < 5; i++) offer($urandom, 32'($urandom_range(4, 1)));
      repeat (8) begin
         cyc();
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL fill cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (pending !== 3'd4 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full pending=%0d ready=%b want 4/0", pending, cmd_ready);
      end
      hs_pct = 70;
      n      = 0;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 1000) begin
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL fill_drain cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      ok = (addr_log.size() == exp_addrs.size()) && (n < 1000) && (done_seen - d0 == 6);
      foreach (exp_addrs[i]) if (ok && addr_log[i] !== exp_addrs[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fill_order addrs=%0d dones=%0d want %0d/6", addr_log.size(),
                  done_seen - d0, exp_addrs.size());
      end
   endtask

   task automatic test_zero_len();
      int n = 0, d0 = done_seen, c0 = cfg_seen;
      logic [31:0] b;
      addr_log.delete();
      b       = $urandom;
      offer($urandom, 32'd0);
      offer(b, 32'd2);
      push_en = 1;
      hs_pct  = 50;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 500) begin
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL zero_len cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (done_seen - d0 != 2 || cfg_seen - c0 != 3 || addr_log.size() != 1 || n >= 500) begin
         n_fail++;
         $display("FAIL zero_len_count dones=%0d cfgs=%0d want 2/3", done_seen - d0,
                  cfg_seen - c0);
      end else begin
         n_cmp++;
         if (addr_log[0] !== b) begin
            n_fail++;
            $display("FAIL zero_len_addr got=%h want=%h", addr_log[0], b);
         end
      end
   endtask

   task automatic test_early_hs();
      int n = 0;
      offer($urandom, 32'd3);
      push_en = 1;
      hs_pct  = 100;
      hs_mask = 1;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 100) begin
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL early_hs cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      hs_mask = 0;
      n_cmp++;
      if (done_obs_cyc - id_obs_cyc != 4 || n >= 100) begin
         n_fail++;
         $display("FAIL early_hs_latency id_to_done=%0d want 4", done_obs_cyc - id_obs_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0, d0;
      for (int i = 0; i < 3; i++) offer($urandom, 32'd5);
      push_en = 1;
      hs_pct  = 0;
      while (!(act && cyc_n - pop_c >= 4 && mq.size() == 2) && n < 50) begin
         cyc();
         n++;
      end
      d0      = done_seen;
      drv_rst = 1;
      cyc();
      drv_rst = 0;
      repeat (2) begin
         cyc();
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (obs_v !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1} || done_seen != d0) begin
         n_fail++;
         $display("FAIL reset_mid_state got=%h dones=%0d want idle, no done", obs_v,
                  done_seen - d0);
      end
      offer($urandom, 32'd2);
      hs_pct = 60;
      n      = 0;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 500) begin
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL reset_mid_rerun cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (done_seen - d0 != 1) begin
         n_fail++;
         $display("FAIL reset_mid_done dones=%0d want 1", done_seen - d0);
      end
   endtask

   task automatic test_push_pop();
      int n = 0;
      bit ok;
      addr_log.delete();
      exp_addrs.delete();
      offer($urandom, 32'd1);
      offer($urandom, 32'($urandom_range(3, 1)));
      offer($urandom, 32'($urandom_range(3, 1)));
      push_en = 1;
      hs_pct  = 0;
      while (!(act && mq.size() == 2 && tx_q.size() == 0) && n < 50) begin
         cyc();
         n++;
      end
      push_en = 0;
      offer($urandom, 32'($urandom_range(3, 1)));
      hs_pct = 100;
      n      = 0;
      while (!(!act && done_c >= 0 && cyc_n == done_c + 1) && n < 50) begin
         cyc();
         n++;
      end
      push_en = 1;
      repeat (2) begin
         cyc();
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL push_pop cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      n_cmp++;
      if (pending !== 3'd2) begin
         n_fail++;
         $display("FAIL push_pop_pending got=%0d want=2", pending);
      end
      n = 0;
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 500) begin
         cyc();
         n++;
      end
      ok = (addr_log.size() == exp_addrs.size());
      foreach (exp_addrs[i]) if (ok && addr_log[i] !== exp_addrs[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL push_pop_order addrs=%0d want=%0d", addr_log.size(), exp_addrs.size());
      end
   endtask

   task automatic test_random();
      int n = 0;
      bit ok;
      addr_log.delete();
      exp_addrs.delete();
      for (int i = 0; i < 12; i++) offer($urandom, 32'($urandom_range(6)));
      while ((tx_q.size() != 0 || mq.size() != 0 || act) && n < 3000) begin
         push_en = ($urandom_range(3) != 0);
         hs_pct  = $urandom_range(90, 30);
         cyc();
         n++;
         if (chk) begin
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_fail++;
               $display("FAIL random cyc=%0d got=%h want=%h", cyc_n - 1, obs_v, exp_v);
            end
         end
      end
      ok = (addr_log.size() == exp_addrs.size()) && (n < 3000);
      foreach (exp_addrs[i]) if (ok && addr_log[i] !== exp_addrs[i]) ok = 0;
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL random_order addrs=%0d want=%0d", addr_log.size(), exp_addrs.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      str_valid = 1'b0;
      str_ready = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_zero_len();
      test_early_hs();
      test_reset_mid();
      test_push_pop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
